// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, total helpers and FSM state type for the LCD timing driver.
package lcd_timing_pkg;

  localparam int unsigned CNT_W = 12;

  localparam int unsigned DEF_H_SYNC   = 41;
  localparam int unsigned DEF_H_BP     = 2;
  localparam int unsigned DEF_H_ACTIVE = 480;
  localparam int unsigned DEF_H_FP     = 2;
  localparam int unsigned DEF_V_SYNC   = 10;
  localparam int unsigned DEF_V_BP     = 2;
  localparam int unsigned DEF_V_ACTIVE = 272;
  localparam int unsigned DEF_V_FP     = 2;
  localparam int unsigned DEF_DATA_W   = 16;

  // Clocks per line.
  function automatic int unsigned h_total(input int unsigned sync, input int unsigned bp,
                                          input int unsigned active, input int unsigned fp);
    return sync + bp + active + fp;
  endfunction

  // Lines per frame.
  function automatic int unsigned v_total(input int unsigned sync, input int unsigned bp,
                                          input int unsigned active, input int unsigned fp);
    return sync + bp + active + fp;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lcd_state_t;

endpackage

// File: rtl/lcd_timing_cnt.sv
// Horizontal/vertical raster counters with sync and active-region decode.
module lcd_timing_cnt
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP
) (
  input  logic lcd_clk,
  input  logic rst,
  input  logic en,
  output logic frame_end,
  output logic hs_int,
  output logic vs_int,
  output logic act
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(h_total(H_SYNC, H_BP, H_ACTIVE, H_FP) - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(v_total(V_SYNC, V_BP, V_ACTIVE, V_FP) - 1);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Counters sit at zero while disabled so the first enabled cycle is position (0,0).
  always_ff @(posedge lcd_clk) begin
    if (rst || !en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Region decode, forced inactive while disabled.
  always_comb begin
    frame_end = en && h_last && v_last;
    hs_int    = en && (h_cnt < HS_END);
    vs_int    = en && (v_cnt < VS_END);
    act       = en && (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI)
                   && (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
  end

endmodule

// File: rtl/lcd_timing_drv.sv
// LCD raster timing driver: frame-sync start, FIFO pixel pull, aligned HS/VS/DE/RGB outputs.
module lcd_timing_drv
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic              lcd_clk,
  input  logic              rst,
  input  logic              lcd_framesync,
  output logic              lcd_data_requst,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [DATA_W-1:0] lcd_rgb,
  output logic              lcd_underflow
);

  lcd_state_t state;
  logic       run;
  logic       uf_pending;
  logic       uf_now;
  logic       frame_end;
  logic       hs_int;
  logic       vs_int;
  logic       act;

  logic       req_d;
  logic       uf_d;
  logic       hs_p0;
  logic       vs_p0;
  logic       hs_p1;
  logic       vs_p1;

  assign run    = (state == RUN);
  assign uf_now = lcd_data_requst && fifo_empty;

  lcd_timing_cnt #(
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP)
  ) u_cnt (
    .lcd_clk   (lcd_clk),
    .rst       (rst),
    .en        (run),
    .frame_end (frame_end),
    .hs_int    (hs_int),
    .vs_int    (vs_int),
    .act       (act)
  );

  // Run/idle control; an underflow forces a resync at frame end unless a new frame is already ready.
  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      state      <= IDLE;
      uf_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lcd_framesync) state <= RUN;
        end
        RUN: begin
          if (uf_now) uf_pending <= 1'b1;
          if (frame_end) begin
            if (lcd_framesync) begin
              uf_pending <= 1'b0;
            end else if (uf_pending || uf_now) begin
              state      <= IDLE;
              uf_pending <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request stage, then two stages so every panel output lines up with the fetched pixel.
  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      lcd_data_requst <= 1'b0;
      hs_p0           <= 1'b1;
      vs_p0           <= 1'b1;
      req_d           <= 1'b0;
      uf_d            <= 1'b0;
      hs_p1           <= 1'b1;
      vs_p1           <= 1'b1;
      lcd_de          <= 1'b0;
      lcd_rgb         <= '0;
      lcd_hs          <= 1'b1;
      lcd_vs          <= 1'b1;
      lcd_underflow   <= 1'b0;
    end else begin
      lcd_data_requst <= act;
      hs_p0           <= ~hs_int;
      vs_p0           <= ~vs_int;
      req_d           <= lcd_data_requst;
      uf_d            <= uf_now;
      hs_p1           <= hs_p0;
      vs_p1           <= vs_p0;
      lcd_de          <= req_d;
      lcd_rgb         <= (req_d && !uf_d) ? fifo_rd_data : '0;
      lcd_hs          <= hs_p1;
      lcd_vs          <= vs_p1;
      if (uf_now) lcd_underflow <= 1'b1;
    end
  end

endmodule

// File: doc/lcd_timing_drv.md
# lcd_timing_drv

LCD panel timing driver, directly downstream of the FIFO control stage in the LCD display path. It generates HS/VS/DE raster timing for a parallel-RGB panel, issues `lcd_data_requst` to pull one pixel per active cycle from the line FIFO, and forwards pixel data to the panel. It starts a raster only after `lcd_framesync`, and it resynchronises after any FIFO underflow.

## Interface
- `H_SYNC`, 41: HS pulse width, in clocks.
- `H_BP`, 2: horizontal back porch.
- `H_ACTIVE`, 480: active pixels per line.
- `H_FP`, 2: horizontal front porch.
- `V_SYNC`, 10: VS pulse width, in lines.
- `V_BP`, 2; `V_ACTIVE`, 272; `V_FP`, 2: vertical back porch, active lines, front porch.
- `DATA_W`, 16: pixel width (RGB565).

Ports:
- `lcd_clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `lcd_framesync`  in  1  frame-data-ready from FIFO control; already in the `lcd_clk` domain.
- `lcd_data_requst`  out  1  FIFO read request, one pixel per high cycle.
- `fifo_rd_data`  in  DATA_W  FIFO read data, valid the cycle after a request.
- `fifo_empty`  in  1  FIFO empty flag.
- `lcd_hs`, `lcd_vs`  out  1  sync outputs, active low.
- `lcd_de`  out  1  data enable.
- `lcd_rgb`  out  DATA_W  pixel data.
- `lcd_underflow`  out  1  sticky underflow flag.

## Operation
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (default 525); V_TOTAL likewise (default 286).
- Counters `h_cnt`/`v_cnt` are 12-bit unsigned. `h_cnt` wraps at H_TOTAL-1 and increments `v_cnt`; `v_cnt` wraps at V_TOTAL-1.
- FSM states:
  - IDLE: counters held at 0.
  - RUN: counters advance every clock.
- Transitions:
  - IDLE → RUN when `lcd_framesync`=1. Counters are 0 in the first RUN cycle.
  - RUN → RUN at frame end (h=H_TOTAL-1, v=V_TOTAL-1) when no underflow is pending.
  - RUN → IDLE at frame end when underflow is pending, unless `lcd_framesync`=1 in that same cycle. In that case RUN restarts at 0 and the pending flag is cleared.
  - `lcd_framesync` in RUN other than at frame end is ignored.
- Region decode (RUN only):
  - hs_int = h_cnt < H_SYNC; vs_int = v_cnt < V_SYNC.
  - act = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- Underflow: a cycle with `lcd_data_requst`=1 and `fifo_empty`=1 sets `lcd_underflow` (sticky until `rst`) and the pending flag. The matching pixel is output as 0.
- IDLE outputs: `lcd_hs`=1, `lcd_vs`=1, `lcd_de`=0, `lcd_rgb`=0, `lcd_data_requst`=0.

## Timing
- Reset values: `lcd_hs`=1, `lcd_vs`=1, `lcd_de`=0, `lcd_rgb`=0, `lcd_data_requst`=0, `lcd_underflow`=0; FSM in IDLE, counters 0, pending flag 0.
- `rst` mid-frame returns everything to the reset values on the next edge. No partial line is finished.
- Pipeline:
  - `lcd_data_requst` is registered from act and is high at cycle T for counter position P.
  - `fifo_rd_data` is valid at T+1.
  - `lcd_rgb` and `lcd_de` are registered and valid at T+2.
  - `lcd_hs`/`lcd_vs` are delayed two cycles so all panel outputs stay aligned to the same P.
- Requests per frame: exactly H_ACTIVE×V_ACTIVE, in contiguous runs of H_ACTIVE cycles, with no gaps inside a line.
- IDLE→RUN latency: `lcd_framesync` high at edge N; first `lcd_vs`/`lcd_hs` low at N+3.

## Structure
- Shared package `lcd_timing_pkg`:
  - default timing constants and the H_TOTAL/V_TOTAL functions;
  - counter width constant (12);
  - FSM state typedef {IDLE, RUN}.
- Sub-module `lcd_timing_cnt`: h/v counters with wrap, `frame_end`, `hs_int`, `vs_int`, `act`.
- Top level holds the FSM, the underflow logic and the two-stage output pipeline.

## Test plan
Bench parameters: H_SYNC=4, H_BP=2, H_ACTIVE=8, H_FP=2, V_SYNC=2, V_BP=1, V_ACTIVE=4, V_FP=1, giving H_TOTAL=16 and V_TOTAL=8.
1. Reset, no `lcd_framesync` for 100 cycles → all outputs at reset values, zero requests.
2. One-cycle `lcd_framesync`, FIFO always non-empty with incrementing data → per frame:
   - 32 requests in 4 runs of 8;
   - `lcd_de` high exactly 2 cycles after each request, with `lcd_rgb` matching the FIFO data;
   - HS low 4 of every 16 cycles; VS low 32 cycles per 128-cycle frame.
3. `fifo_empty`=1 during the 3rd request of line 2 → that pixel output is 0, `lcd_underflow`=1 and stays set; at frame end FSM enters IDLE with HS=VS=1, DE=0.
4. Underflow pending and `lcd_framesync`=1 exactly at frame end → next frame starts immediately with no IDLE cycle; `lcd_underflow` stays 1.
5. `lcd_framesync` pulses mid-frame in RUN → raster is unaffected, request count per frame stays 32.
6. `rst` asserted mid-line during active data → next cycle outputs at reset values; a later `lcd_framesync` restarts cleanly from h=0, v=0.
